param_shadow_bank: RTL and testbench

//  Parametrised per-channel parameter store between the host endpoints and the datapath
//  (osf / pid / opp). Host writes land in shadow registers, addressed by channel and slot.
//  A commit copies the selected channels' shadow registers into their active registers

---
 rtl/param_shadow_bank_if.sv | 39 +++
 rtl/param_shadow_bank.sv | 81 ++++++++
 tb/tb_param_shadow_bank.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/param_shadow_bank_if.sv
// param_shadow_bank_if: host write/commit/readback bus and datapath-facing outputs of the parameter store
interface param_shadow_bank_if #(
    parameter int N_CHAN = 8,
    parameter int N_SLOT = 8,
    parameter int W_DATA = 16,
    parameter int W_CHAN = 3,
    parameter int W_SLOT = 3
) ();
    logic                             wr_en_in;
    logic [W_CHAN-1:0]                wr_chan_in;
    logic [W_SLOT-1:0]                wr_slot_in;
    logic [W_DATA-1:0]                wr_data_in;
    logic                             commit_in;
    logic [N_CHAN-1:0]                commit_mask_in;
    logic                             rd_en_in;
    logic [W_CHAN-1:0]                rd_chan_in;
    logic [W_SLOT-1:0]                rd_slot_in;
    logic                             rd_active_in;
    logic [W_DATA-1:0]                rd_data_out;
    logic                             rd_valid_out;
    logic [N_CHAN*N_SLOT*W_DATA-1:0]  active_out;
    logic [N_CHAN-1:0]                update_out;
    logic [N_CHAN-1:0]                dirty_out;
    logic                             addr_err_out;

    modport master (
        output wr_en_in, wr_chan_in, wr_slot_in, wr_data_in,
        output commit_in, commit_mask_in,
        output rd_en_in, rd_chan_in, rd_slot_in, rd_active_in,
        input  rd_data_out, rd_valid_out, active_out, update_out, dirty_out, addr_err_out
    );

    modport slave (
        input  wr_en_in, wr_chan_in, wr_slot_in, wr_data_in,
        input  commit_in, commit_mask_in,
        input  rd_en_in, rd_chan_in, rd_slot_in, rd_active_in,
        output rd_data_out, rd_valid_out, active_out, update_out, dirty_out, addr_err_out
    );
endinterface

// File: rtl/param_shadow_bank.sv
// param_shadow_bank: per-channel shadow/active parameter store with atomic masked commit and registered readback
module param_shadow_bank #(
    parameter int N_CHAN = 8,
    parameter int N_SLOT = 8,
    parameter int W_DATA = 16,
    parameter int W_CHAN = 3,
    parameter int W_SLOT = 3
) (
    input logic               clk50_in,
    input logic               reset_in,
    param_shadow_bank_if.slave bus
);
    logic [N_CHAN-1:0][N_SLOT-1:0][W_DATA-1:0] shadow;
    logic [N_CHAN-1:0][N_SLOT-1:0][W_DATA-1:0] active;
    logic [N_CHAN-1:0] dirty;
    logic [N_CHAN-1:0] update;
    logic [N_CHAN-1:0] wr_hit;
    logic [N_CHAN-1:0] commit_hit;
    logic              wr_ok;
    logic              rd_ok;
    logic [W_DATA-1:0] rd_word;
    logic [W_DATA-1:0] rd_data;
    logic              rd_valid;
    logic              addr_err;

    assign wr_ok = (int'(bus.wr_chan_in) < N_CHAN) && (int'(bus.wr_slot_in) < N_SLOT);
    assign rd_ok = (int'(bus.rd_chan_in) < N_CHAN) && (int'(bus.rd_slot_in) < N_SLOT);

    // A commit only touches masked channels holding uncommitted writes.
    always_comb begin
        wr_hit = '0;
        commit_hit = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            wr_hit[c] = bus.wr_en_in && wr_ok && (bus.wr_chan_in == W_CHAN'(c));
            commit_hit[c] = bus.commit_in && bus.commit_mask_in[c] && dirty[c];
        end
    end

    // Out-of-range reads fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < N_CHAN; c++)
            for (int s = 0; s < N_SLOT; s++)
                if (rd_ok && bus.rd_chan_in == W_CHAN'(c) && bus.rd_slot_in == W_SLOT'(s))
                    rd_word = bus.rd_active_in ? active[c][s] : shadow[c][s];
    end

    // Commit copies the pre-edge shadow, so a same-cycle write stays pending and dirty.
    always_ff @(posedge clk50_in or posedge reset_in) begin
        if (reset_in) begin
            shadow   <= '0;
            active   <= '0;
            dirty    <= '0;
            update   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (commit_hit[c])
                    active[c] <= shadow[c];
                for (int s = 0; s < N_SLOT; s++)
                    if (wr_hit[c] && bus.wr_slot_in == W_SLOT'(s))
                        shadow[c][s] <= bus.wr_data_in;
            end
            dirty    <= (dirty & ~commit_hit) | wr_hit;
            update   <= commit_hit;
            rd_valid <= bus.rd_en_in;
            if (bus.rd_en_in)
                rd_data <= rd_word;
            addr_err <= addr_err | (bus.wr_en_in && !wr_ok) | (bus.rd_en_in && !rd_ok);
        end
    end

    assign bus.active_out   = active;
    assign bus.update_out   = update;
    assign bus.dirty_out    = dirty;
    assign bus.rd_data_out  = rd_data;
    assign bus.rd_valid_out = rd_valid;
    assign bus.addr_err_out = addr_err;
endmodule

// File: tb/tb_param_shadow_bank.sv
// tb_param_shadow_bank: directed checks of write, masked commit, write/commit race, readback and reset
module tb_param_shadow_bank;
    localparam int N_CHAN = 8;
    localparam int N_SLOT = 8;
    localparam int W_DATA = 16;
    localparam int W_CHAN = 4;
    localparam int W_SLOT = 4;

    logic clk50_in = 1'b0;
    logic reset_in = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [W_DATA-1:0] rd;

    always #10 clk50_in = ~clk50_in;

    param_shadow_bank_if #(.N_CHAN(N_CHAN), .N_SLOT(N_SLOT), .W_DATA(W_DATA),
                           .W_CHAN(W_CHAN), .W_SLOT(W_SLOT)) bus ();

    param_shadow_bank #(.N_CHAN(N_CHAN), .N_SLOT(N_SLOT), .W_DATA(W_DATA),
                        .W_CHAN(W_CHAN), .W_SLOT(W_SLOT)) dut (
        .clk50_in (clk50_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W_DATA-1:0] word(input int c, input int s);
        return bus.active_out[(c*N_SLOT+s)*W_DATA +: W_DATA];
    endfunction

    task automatic idle();
        bus.wr_en_in = 0; bus.wr_chan_in = '0; bus.wr_slot_in = '0; bus.wr_data_in = '0;
        bus.commit_in = 0; bus.commit_mask_in = '0;
        bus.rd_en_in = 0; bus.rd_chan_in = '0; bus.rd_slot_in = '0; bus.rd_active_in = 0;
    endtask

    task automatic step();
        @(posedge clk50_in);
        #1;
        idle();
    endtask

    task automatic set_wr(input int c, input int s, input logic [W_DATA-1:0] d);
        bus.wr_en_in = 1; bus.wr_chan_in = W_CHAN'(c); bus.wr_slot_in = W_SLOT'(s); bus.wr_data_in = d;
    endtask

    task automatic set_rd(input int c, input int s, input logic act);
        bus.rd_en_in = 1; bus.rd_chan_in = W_CHAN'(c); bus.rd_slot_in = W_SLOT'(s); bus.rd_active_in = act;
    endtask

    task automatic write(input int c, input int s, input logic [W_DATA-1:0] d);
        set_wr(c, s, d);
        step();
    endtask

    task automatic commit(input logic [N_CHAN-1:0] m);
        bus.commit_in = 1; bus.commit_mask_in = m;
        step();
    endtask

    task automatic read(input int c, input int s, input logic act, output logic [W_DATA-1:0] d);
        set_rd(c, s, act);
        step();
        d = bus.rd_data_out;
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk50_in);
        #1 reset_in = 0;
        chk("rst_active", 32'(bus.active_out == '0), 1);
        chk("rst_dirty", 32'(bus.dirty_out), 0);
        chk("rst_update", 32'(bus.update_out), 0);
        chk("rst_err", 32'(bus.addr_err_out), 0);
        chk("rst_valid", 32'(bus.rd_valid_out), 0);

        write(2, 1, 16'h1234);
        chk("t2_dirty", 32'(bus.dirty_out), 32'h04);
        chk("t2_word_pre", 32'(word(2, 1)), 0);
        commit(8'hFF);
        chk("t2_update", 32'(bus.update_out), 32'h04);
        chk("t2_word", 32'(word(2, 1)), 32'h1234);
        chk("t2_dirty_clr", 32'(bus.dirty_out), 0);
        step();
        chk("t2_pulse_end", 32'(bus.update_out), 0);

        write(0, 0, 16'hAAAA);
        write(5, 7, 16'h5555);
        chk("t3_dirty", 32'(bus.dirty_out), 32'h21);
        commit(8'h01);
        chk("t3_update0", 32'(bus.update_out), 32'h01);
        chk("t3_word00", 32'(word(0, 0)), 32'hAAAA);
        chk("t3_word57_held", 32'(word(5, 7)), 0);
        chk("t3_dirty5", 32'(bus.dirty_out), 32'h20);
        commit(8'h20);
        chk("t3_update5", 32'(bus.update_out), 32'h20);
        chk("t3_word57", 32'(word(5, 7)), 32'h5555);
        commit(8'hFF);
        chk("t3_b2b_nopulse", 32'(bus.update_out), 0);

        write(3, 0, 16'h0001);
        chk("t4_dirty", 32'(bus.dirty_out), 32'h08);
        set_wr(3, 0, 16'hBEEF);
        commit(8'h08);
        chk("t4_active", 32'(word(3, 0)), 32'h0001);
        chk("t4_update", 32'(bus.update_out), 32'h08);
        chk("t4_dirty_kept", 32'(bus.dirty_out), 32'h08);
        read(3, 0, 0, rd);
        chk("t4_shadow", 32'(rd), 32'hBEEF);
        chk("t4_valid", 32'(bus.rd_valid_out), 1);
        read(3, 0, 1, rd);
        chk("t4_rd_active", 32'(rd), 32'h0001);
        step();
        chk("t4_valid_low", 32'(bus.rd_valid_out), 0);
        chk("t4_rd_hold", 32'(bus.rd_data_out), 32'h0001);
        set_wr(3, 0, 16'h1111);
        read(3, 0, 0, rd);
        chk("t4_rd_race", 32'(rd), 32'hBEEF);
        read(3, 0, 0, rd);
        chk("t4_rd_after", 32'(rd), 32'h1111);

        chk("t5_err_pre", 32'(bus.addr_err_out), 0);
        write(7, N_SLOT, 16'hFFFF);
        chk("t5_err", 32'(bus.addr_err_out), 1);
        chk("t5_dirty", 32'(bus.dirty_out), 32'h08);
        read(7, 0, 0, rd);
        chk("t5_nostore", 32'(rd), 0);
        read(N_CHAN, 0, 0, rd);
        chk("t5_rd_zero", 32'(rd), 0);
        chk("t5_rd_valid", 32'(bus.rd_valid_out), 1);
        step();
        chk("t5_err_sticky", 32'(bus.addr_err_out), 1);

        write(4, 2, 16'h7777);
        #3 reset_in = 1;
        #1;
        chk("t6_async_active", 32'(bus.active_out == '0), 1);
        chk("t6_async_dirty", 32'(bus.dirty_out), 0);
        chk("t6_async_err", 32'(bus.addr_err_out), 0);
        step();
        step();
        reset_in = 0;
        commit(8'hFF);
        chk("t6_nopulse", 32'(bus.update_out), 0);
        chk("t6_active", 32'(bus.active_out == '0), 1);
        read(4, 2, 0, rd);
        chk("t6_shadow", 32'(rd), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
